// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier scheduler and its core.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 4;

  // First set bit of vld searching ptr+1, ptr+2, ... modulo n (n <= 32).
  // Returns ptr when no bit is set, so callers must qualify with |vld.
  function automatic int rr_next(input int ptr, input logic [31:0] vld, input int n);
    int idx;
    int res;
    res = ptr;
    for (int k = 32; k >= 1; k--) begin
      if (k <= n) begin
        idx = (ptr + k) % n;
        if (((vld >> idx) & 32'd1) != 32'd0) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/booth_core.sv
// Iterative radix-2 Booth multiplier: one iteration per cycle, WIDTH cycles per product.
module booth_core
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic                      done,
  output logic signed [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic signed [WIDTH:0] acc, m, acc_sel, acc_nx;
  logic [WIDTH-1:0]      q, q_nx;
  logic                  q_m1;
  logic [CW-1:0]         cnt;

  always_comb begin
    acc_sel = acc;
    case ({q[0], q_m1})
      2'b10:   acc_sel = acc - m;
      2'b01:   acc_sel = acc + m;
      default: acc_sel = acc;
    endcase
    acc_nx = acc_sel >>> 1;
    q_nx   = {acc_sel[0], q[WIDTH-1:1]};
  end

  // done flags the final iteration; prod is that iteration's result so the
  // owner can capture it on the same edge.
  assign done = (cnt == CW'(1));
  assign prod = {acc_nx[WIDTH-1:0], q_nx};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      m    <= '0;
      q    <= '0;
      q_m1 <= 1'b0;
      cnt  <= '0;
    end else if (cnt == '0) begin
      if (start) begin
        acc  <= '0;
        m    <= {a[WIDTH-1], a};
        q    <= b;
        q_m1 <= 1'b0;
        cnt  <= CW'(WIDTH);
      end
    end else begin
      acc  <= acc_nx;
      q    <= q_nx;
      q_m1 <= q[0];
      cnt  <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one Booth multiplier core among NREQ requesters.
module booth_mul_sched
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic signed [2*WIDTH-1:0] rsp_prod,
  input  logic                      rsp_ready,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);

  state_t                    state_q, state_d;
  logic [IDW-1:0]            rr_ptr, gnt_id;
  logic                      grant_fire;
  logic signed [WIDTH-1:0]   gnt_a, gnt_b;
  logic                      core_done;
  logic signed [2*WIDTH-1:0] core_prod;

  assign gnt_id     = IDW'(rr_next(int'(rr_ptr), 32'(req_valid), NREQ));
  // Ready is suppressed while reset is asserted: no accept can happen on that edge.
  assign grant_fire = (state_q == ST_IDLE) && (|req_valid) && !reset;
  assign gnt_a      = req_a[gnt_id*WIDTH +: WIDTH];
  assign gnt_b      = req_b[gnt_id*WIDTH +: WIDTH];
  assign busy       = (state_q != ST_IDLE);

  booth_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .start (grant_fire),
    .a     (gnt_a),
    .b     (gnt_b),
    .done  (core_done),
    .prod  (core_prod)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: if (grant_fire) begin
        req_ready[gnt_id] = 1'b1;
        state_d           = ST_RUN;
      end
      ST_RUN:  if (core_done) state_d = ST_DONE;
      ST_DONE: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // rr_ptr doubles as the owner ID of the in-flight product.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr    <= IDW'(NREQ - 1);
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_prod  <= '0;
    end else begin
      state_q <= state_d;
      if (grant_fire) rr_ptr <= gnt_id;
      if (state_q == ST_RUN && core_done) begin
        rsp_valid <= 1'b1;
        rsp_id    <= rr_ptr;
        rsp_prod  <= core_prod;
      end else if (state_q == ST_DONE && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
